// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: the operation encoding and the NZCV flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational N-bit ALU: result plus NZCV flags from op, a and b.
// Shared by the single-cycle wrapper and the pipelined alu_pipe.
module alu_core
    import alu_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  alu_op_t          op,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [N-1:0]     result,
    output alu_flags_t       flags
);

    logic         sub_mode;
    logic [N-1:0] b_eff;
    logic [N-1:0] sum;
    logic         carry;
    logic         ovf;
    logic [SHW-1:0] shamt;

    // Single adder serves ADD, SUB and the SLT comparison (SUB and SLT use a + ~b + 1).
    always_comb begin
        sub_mode     = (op == OP_SUB) || (op == OP_SLT);
        b_eff        = sub_mode ? ~b : b;
        {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub_mode};
        ovf          = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
        shamt        = b[SHW-1:0];
    end

    // Result select and flag generation; C and V only carry meaning for ADD/SUB.
    always_comb begin
        result  = '0;
        flags   = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                result  = sum;
                flags.c = carry;
                flags.v = ovf;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            // signed less-than: sign of the difference corrected by its overflow
            OP_SLT: result = {{(N-1){1'b0}}, sum[N-1] ^ ovf};
            OP_SLL: result = a << shamt;
            OP_SRL: result = a >> shamt;
            default: result = '0;
        endcase
        flags.n = result[N-1];
        flags.z = (result == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides,
// accumulator operand mode and a sticky overflow indicator.
// S1 holds the accepted operation; compute happens as S1 moves into S2, which drives the outputs.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  alu_op_t      in_op,
    input  logic         in_acc,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output alu_flags_t   out_flags,
    output logic         sticky_v,
    input  logic         sticky_clr
);

    logic         s1_valid;
    alu_op_t      s1_op;
    logic         s1_acc;
    logic [N-1:0] s1_a;
    logic [N-1:0] s1_b;

    logic         s2_valid;
    logic [N-1:0] s2_result;
    alu_flags_t   s2_flags;

    logic [N-1:0] acc_q;
    logic         sticky_q;

    logic         s1_adv;
    logic         s2_adv;
    logic         accept;
    logic [N-1:0] core_a;
    logic [N-1:0] core_result;
    alu_flags_t   core_flags;

    // Handshake: S2 frees when empty or consumed; S1 moves when it has an op and S2 frees.
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = s1_valid && s2_adv;
        in_ready = !s1_valid || s2_adv;
        accept   = in_valid && in_ready;
        // accumulator holds the result of the previous op in program order at this compute edge
        core_a   = s1_acc ? acc_q : s1_a;
    end

    alu_core #(.N(N), .SHW(SHW)) u_core (
        .op     (s1_op),
        .a      (core_a),
        .b      (s1_b),
        .result (core_result),
        .flags  (core_flags)
    );

    // Stage 1: capture the offered operation on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_acc   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_acc   <= in_acc;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: capture the computed result; hold it while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s1_adv) begin
            s2_valid  <= 1'b1;
            s2_result <= core_result;
            s2_flags  <= core_flags;
        end else if (out_ready) begin
            s2_valid  <= 1'b0;
        end
    end

    // Accumulator follows every computed result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (s1_adv) begin
            acc_q <= core_result;
        end
    end

    // Sticky overflow: a new overflow in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= (s1_adv && core_flags.v) || (sticky_q && !sticky_clr);
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_flags  = s2_flags;
    assign sticky_v   = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a queue-based reference model checked on every valid output cycle,
// plus directed vectors with hand-computed results.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    alu_op_t      in_op = OP_ADD;
    logic         in_acc = 1'b0;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out_result;
    logic [3:0]   out_flags;
    logic         sticky_v;
    logic         sticky_clr = 1'b0;

    int tests = 0;
    int fails = 0;
    int rx_count = 0;
    logic [35:0] exp_q[$];
    logic [31:0] m_acc = '0;
    logic [35:0] m_e;

    alu_pipe #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .sticky_v   (sticky_v),
        .sticky_clr (sticky_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {result, N, Z, C, V}.
    function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint lim = 64'sd2147483647;
        longint t;
        logic [31:0] r;
        logic c;
        logic v;
        logic [4:0] sh;
        c = 1'b0;
        v = 1'b0;
        sh = b[4:0];
        case (op)
            3'd0: begin
                r = a + b;
                c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
                t = sa + sb;
                v = (t > lim) || (t < -lim - 1);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                t = sa - sb;
                v = (t > lim) || (t < -lim - 1);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: r = a << sh;
            default: r = a >> sh;
        endcase
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    // Compare process: every cycle with out_valid, the head of the expected queue must be shown.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_acc = '0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_out: got result 0x%0h with no pending op", out_result);
                end else begin
                    chk("model_result", 64'(out_result), 64'(exp_q[0][35:4]));
                    chk("model_flags", 64'(out_flags), 64'(exp_q[0][3:0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        rx_count++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                m_e = model(in_op, in_acc ? m_acc : in_a, in_b);
                exp_q.push_back(m_e);
                m_acc = m_e[35:4];
            end
        end
    end

    // Offer one op (called at posedge+1); returns just after the accepting edge.
    task automatic issue(input alu_op_t op, input logic acc, input logic [31:0] a, input logic [31:0] b);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_op = op;
        in_acc = acc;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: got in_ready=0 for 20 cycles, want 1");
        end
    endtask

    // Wait for the next result and compare it with literals.
    task automatic wait_out(input string name, input logic [31:0] r, input logic [3:0] f);
        bit done;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (out_valid) begin
                chk({name, "_result"}, 64'(out_result), 64'(r));
                chk({name, "_flags"}, 64'(out_flags), 64'(f));
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got out_valid=0 for 20 cycles, want 1", name);
        end
    endtask

    task automatic run1(input string name, input alu_op_t op, input logic acc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] f);
        issue(op, acc, a, b);
        wait_out(name, r, f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rx0;
        int seen;
        bit took;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_out_result", 64'(out_result), 64'd0);
        chk("rel_out_flags", 64'(out_flags), 64'd0);
        chk("rel_sticky", 64'(sticky_v), 64'd0);

        // ADD overflow with latency and sticky timing
        issue(OP_ADD, 1'b0, 32'h7BF05BC3, 32'h24729415);
        chk("lat_after_accept", 64'(out_valid), 64'd0);
        chk("sticky_before_compute", 64'(sticky_v), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_after_compute", 64'(out_valid), 64'd1);
        chk("addovf_result", 64'(out_result), 64'hA062EFD8);
        chk("addovf_flags", 64'(out_flags), 64'b1001);
        chk("sticky_after_compute", 64'(sticky_v), 64'd1);
        @(posedge clk);
        #1;
        chk("addovf_consumed", 64'(out_valid), 64'd0);

        // sticky clear, then clear coinciding with a new overflow
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        chk("sticky_cleared", 64'(sticky_v), 64'd0);
        issue(OP_ADD, 1'b0, 32'h7FFFFFFF, 32'h00000001);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        chk("sticky_set_wins", 64'(sticky_v), 64'd1);
        @(posedge clk);
        #1;
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        chk("sticky_cleared2", 64'(sticky_v), 64'd0);

        // Directed vectors
        run1("wrap", OP_ADD, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110);
        run1("sub_borrow", OP_SUB, 1'b0, 32'h1310061E, 32'hD6D9155C, 32'h3C36F0C2, 4'b0000);
        run1("and", OP_AND, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000);
        run1("or", OP_OR, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 4'b1000);
        run1("xor", OP_XOR, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 4'b1000);
        run1("acc0", OP_ADD, 1'b0, 32'd5, 32'd0, 32'd5, 4'b0000);
        run1("acc1", OP_ADD, 1'b1, 32'hDEADBEEF, 32'd3, 32'd8, 4'b0000);
        run1("acc2", OP_SUB, 1'b1, 32'hDEADBEEF, 32'd8, 32'd0, 4'b0110);
        run1("sll", OP_SLL, 1'b0, 32'h00000001, 32'd31, 32'h80000000, 4'b1000);
        run1("srl_wrap", OP_SRL, 1'b0, 32'h80000000, 32'd33, 32'h40000000, 4'b0000);
        run1("slt_neg", OP_SLT, 1'b0, 32'hFFFFFFFF, 32'd0, 32'd1, 4'b0000);
        run1("slt_ovf", OP_SLT, 1'b0, 32'h80000000, 32'd1, 32'd1, 4'b0000);
        run1("slt_false", OP_SLT, 1'b0, 32'd7, 32'hFFFFFFF0, 32'd0, 4'b0100);
        chk("slt_no_sticky", 64'(sticky_v), 64'd0);

        // Back-pressure: four back-to-back ADDs against a stalled consumer
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (sent < 4);
            in_op = OP_ADD;
            in_acc = 1'b0;
            in_a = 32'((sent + 1) * 16);
            in_b = 32'(sent + 1);
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took) sent++;
        end
        chk("bp_accepted", 64'(sent), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_result", 64'(out_result), 64'h11);
        out_ready = 1'b1;
        rx0 = rx_count;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (sent < 4);
            in_a = 32'((sent + 1) * 16);
            in_b = 32'(sent + 1);
            @(negedge clk);
            took = in_valid && in_ready;
            if (c < 4 && out_valid) seen++;
            @(posedge clk);
            #1;
            if (took) sent++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 64'(sent), 64'd4);
        chk("bp_drained", 64'(rx_count - rx0), 64'd4);
        chk("bp_one_per_cycle", 64'(seen), 64'd4);

        // Reset with two ops in flight
        out_ready = 1'b0;
        issue(OP_ADD, 1'b0, 32'h7BF05BC3, 32'h24729415);
        issue(OP_ADD, 1'b0, 32'h7BF05BC3, 32'h24729415);
        chk("pre_reset_sticky", 64'(sticky_v), 64'd1);
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_reset_out_valid", 64'(out_valid), 64'd0);
        chk("post_reset_sticky", 64'(sticky_v), 64'd0);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_no_output", 64'(out_valid), 64'd0);
        run1("rst_acc_zero", OP_ADD, 1'b1, 32'h00001234, 32'd0, 32'd0, 4'b0100);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
